// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: derives 1 us / 1 ms ticks from the board clock,
// raises periodic poll requests for three sensor slots and grants the shared
// sensor-bus engine to one slot at a time with a start/done handshake and
// a per-transaction timeout.
module sensor_poll_scheduler #(
    parameter int CLK_DIV    = 26,
    parameter int US_PER_MS  = 1000,
    parameter int PERIOD0    = 10,
    parameter int PERIOD1    = 100,
    parameter int PERIOD2    = 1000,
    parameter int TIMEOUT_US = 500
) (
    input  logic       CLK_26MHZ_IN,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       DONE,
    input  logic       CLEAR_ERR,
    output logic       TICK_1US,
    output logic [1:0] GRANT,
    output logic       START,
    output logic       BUSY,
    output logic [2:0] MISSED,
    output logic [2:0] TIMEOUT_ERR
);

    localparam int PW   = $clog2(CLK_DIV);
    localparam int UW   = $clog2(US_PER_MS);
    localparam int PMAX = (PERIOD0 > PERIOD1) ? ((PERIOD0 > PERIOD2) ? PERIOD0 : PERIOD2)
                                              : ((PERIOD1 > PERIOD2) ? PERIOD1 : PERIOD2);
    localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int TW   = $clog2(TIMEOUT_US + 1);

    localparam logic [2:0][CW-1:0] RELOAD = {CW'(PERIOD2 - 1), CW'(PERIOD1 - 1), CW'(PERIOD0 - 1)};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    logic [PW-1:0]         presc_q;
    logic [UW-1:0]         us_q;
    logic                  ms_tick;
    logic [2:0][CW-1:0]    cnt_q, cnt_d;
    logic [2:0]            set_ev;
    logic [2:0]            pend_q, pend_d;
    logic [2:0]            clr_pend;
    logic [2:0]            miss_set;
    logic [2:0]            missed_q, missed_d;
    logic [2:0]            terr_q, terr_d;
    logic [TW-1:0]         to_cnt_q;
    logic                  to_hit;
    logic [1:0]            pick;
    state_e                state_q;
    logic [1:0]            grant_q;
    logic                  start_q;
    logic                  busy_q;

    assign TICK_1US    = (presc_q == PW'(CLK_DIV - 1));
    assign ms_tick     = TICK_1US && (us_q == UW'(US_PER_MS - 1));
    assign GRANT       = grant_q;
    assign START       = start_q;
    assign BUSY        = busy_q;
    assign MISSED      = missed_q;
    assign TIMEOUT_ERR = terr_q;

    // Free-running clock prescaler and microsecond counter (independent of ENABLE)
    always_ff @(posedge CLK_26MHZ_IN) begin
        if (!RESET) begin
            presc_q <= '0;
            us_q    <= '0;
        end else begin
            presc_q <= TICK_1US ? '0 : presc_q + 1'b1;
            if (TICK_1US)
                us_q <= ms_tick ? '0 : us_q + 1'b1;
        end
    end

    // Per-slot period countdown; a zero count on ms_tick raises a poll request
    always_comb begin
        cnt_d  = cnt_q;
        set_ev = '0;
        for (int i = 0; i < 3; i++) begin
            if (!ENABLE) begin
                cnt_d[i] = RELOAD[i];
            end else if (ms_tick) begin
                if (cnt_q[i] == '0) begin
                    cnt_d[i]  = RELOAD[i];
                    set_ev[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    // Pending requests do not queue: a new request onto a pending one is an overrun,
    // except when the same slot is being issued this cycle (the new request survives)
    always_comb begin
        pend_d   = pend_q;
        miss_set = '0;
        clr_pend = (state_q == ISSUE) ? (3'b001 << grant_q) : 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (!ENABLE) begin
                pend_d[i] = 1'b0;
            end else if (set_ev[i]) begin
                pend_d[i] = 1'b1;
                if (pend_q[i] && !clr_pend[i])
                    miss_set[i] = 1'b1;
            end else if (clr_pend[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // Timeout fires on the tick that would bring the count to TIMEOUT_US; DONE overrides it
    assign to_hit = (state_q == WAIT) && !DONE && TICK_1US && (to_cnt_q == TW'(TIMEOUT_US - 1));

    // Sticky flags: a new event in the clear cycle survives the clear
    always_comb begin
        missed_d = (CLEAR_ERR ? 3'b000 : missed_q) | miss_set;
        terr_d   = (CLEAR_ERR ? 3'b000 : terr_q) | (to_hit ? (3'b001 << grant_q) : 3'b000);
    end

    // Fixed priority: slot 0 first
    always_comb begin
        casez (pend_q)
            3'b??1:  pick = 2'd0;
            3'b?10:  pick = 2'd1;
            3'b100:  pick = 2'd2;
            default: pick = 2'd0;
        endcase
    end

    // Slot counters, pending bits and sticky flags
    always_ff @(posedge CLK_26MHZ_IN) begin
        if (!RESET) begin
            cnt_q    <= RELOAD;
            pend_q   <= '0;
            missed_q <= '0;
            terr_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            missed_q <= missed_d;
            terr_q   <= terr_d;
        end
    end

    // Grant FSM: IDLE picks a slot, ISSUE pulses START, WAIT holds BUSY until DONE or timeout
    always_ff @(posedge CLK_26MHZ_IN) begin
        if (!RESET) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ENABLE && (pend_q != '0)) begin
                        grant_q <= pick;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q  <= 1'b0;
                    busy_q   <= 1'b1;
                    to_cnt_q <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (DONE || to_hit) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (TICK_1US) begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler with small periods
// (1 us = 4 clocks, 1 ms = 20 clocks). Cycle c counts clock edges since
// reset release; ms_tick lands in cycles 19, 39, 59, ...
module tb_sensor_poll_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       done_auto = 1'b0;
    logic       done_man = 1'b0;
    logic       done;
    logic       done_b = 1'b0;
    logic       clr = 1'b0;
    bit         auto_en = 1'b0;
    int         dly = 0;

    logic       tick, start, busy;
    logic [1:0] grant;
    logic [2:0] missed, terr;
    logic       tick_b, start_b, busy_b;
    logic [1:0] grant_b;
    logic [2:0] missed_b, terr_b;

    int cyc = 0;
    int nchk = 0;
    int nerr = 0;

    assign done = done_auto | done_man;

    sensor_poll_scheduler #(
        .CLK_DIV(4), .US_PER_MS(5), .PERIOD0(1), .PERIOD1(2), .PERIOD2(4), .TIMEOUT_US(3)
    ) dut (
        .CLK_26MHZ_IN(clk), .RESET(rst_n), .ENABLE(en), .DONE(done), .CLEAR_ERR(clr),
        .TICK_1US(tick), .GRANT(grant), .START(start), .BUSY(busy),
        .MISSED(missed), .TIMEOUT_ERR(terr)
    );

    // Same schedule with a longer timeout and DONE never returned
    sensor_poll_scheduler #(
        .CLK_DIV(4), .US_PER_MS(5), .PERIOD0(1), .PERIOD1(2), .PERIOD2(4), .TIMEOUT_US(10)
    ) dut_b (
        .CLK_26MHZ_IN(clk), .RESET(rst_n), .ENABLE(en), .DONE(done_b), .CLEAR_ERR(clr),
        .TICK_1US(tick_b), .GRANT(grant_b), .START(start_b), .BUSY(busy_b),
        .MISSED(missed_b), .TIMEOUT_ERR(terr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = rst_n ? cyc + 1 : 0;

    // Engine responder: DONE in the second cycle after START
    always @(negedge clk) begin
        done_auto = 1'b0;
        if (dly != 0) begin
            dly = dly - 1;
            if (dly == 0) done_auto = 1'b1;
        end
        if (auto_en && start) dly = 2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @c=%0d: got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset(input logic en_v, input bit auto_v);
        rst_n    = 1'b0;
        en       = en_v;
        auto_en  = auto_v;
        done_man = 1'b0;
        clr      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tick",   tick,   0);
        chk("rst_grant",  grant,  0);
        chk("rst_start",  start,  0);
        chk("rst_busy",   busy,   0);
        chk("rst_missed", missed, 0);
        chk("rst_terr",   terr,   0);
        rst_n = 1'b1;
    endtask

    // Hand-computed START cycles and slots with DONE two cycles after each START
    int st_cyc [14] = '{21, 41, 45, 61, 81, 85, 89, 101, 121, 125, 141, 161, 165, 169};
    int st_slot[14] = '{ 0,  0,  1,  0,  0,  1,  2,   0,   0,   1,   0,   0,   1,   2};

    function automatic int exp_slot(input int c);
        for (int k = 0; k < 14; k++)
            if (st_cyc[k] == c) return st_slot[k];
        return -1;
    endfunction

    initial begin
        @(negedge clk);

        // Disabled: tick cadence only, never a START
        do_reset(1'b0, 1'b0);
        for (int c = 1; c <= 60; c++) begin
            at(c);
            chk("t1_tick",  tick,  (c % 4 == 3));
            chk("t1_start", start, 0);
        end
        chk("t1_busy",   busy,   0);
        chk("t1_missed", missed, 0);
        chk("t1_terr",   terr,   0);

        // Enabled with prompt DONE: periodic schedule and collision order
        do_reset(1'b1, 1'b1);
        for (int c = 1; c <= 180; c++) begin
            int s;
            at(c);
            s = exp_slot(c);
            chk("t2_start", start, (s >= 0));
            if (s >= 0) chk("t2_grant", grant, s);
        end
        chk("t2_missed", missed, 0);
        chk("t2_terr",   terr,   0);

        // DONE withheld: timeout on slot 0, clear, timeout again; dut_b overruns
        do_reset(1'b1, 1'b0);
        at(21); chk("t3_start", start, 1); chk("t3_grant", grant, 0);
        at(22); chk("t3_busy_in", busy, 1);
        at(31); chk("t3_busy_last", busy, 1); chk("t3_terr_pre", terr, 0);
        at(32); chk("t3_busy_out", busy, 0); chk("t3_terr", terr, 3'b001);
        chk("t3_grant_hold", grant, 0);
        at(33); clr = 1'b1;
        at(34); clr = 1'b0; chk("t3_terr_clr", terr, 0);
        at(52); chk("t3_terr_again", terr, 3'b001); chk("t3_missed", missed, 0);
        at(59); chk("t3b_missed_pre", missed_b, 0); chk("t3b_terr_pre", terr_b, 0);
        at(60); chk("t3b_missed", missed_b, 3'b001); chk("t3b_terr", terr_b, 3'b001);

        // DONE on the timeout tick wins; DONE while idle is ignored
        do_reset(1'b1, 1'b0);
        at(21); chk("t4_start", start, 1);
        at(31); done_man = 1'b1; chk("t4_busy", busy, 1);
        at(32); done_man = 1'b0; chk("t4_busy_out", busy, 0); chk("t4_terr", terr, 0);
        at(33); done_man = 1'b1;
        at(34); done_man = 1'b0;
        chk("t4_idle_busy", busy, 0); chk("t4_idle_start", start, 0);
        chk("t4_idle_grant", grant, 0); chk("t4_idle_terr", terr, 0);
        at(41); chk("t4_next_start", start, 1); chk("t4_next_grant", grant, 0);

        // Reset in the middle of a slot-1 WAIT
        do_reset(1'b1, 1'b1);
        at(45); chk("t5_start", start, 1); chk("t5_grant", grant, 1);
        at(46); chk("t5_busy", busy, 1); chk("t5_grant_w", grant, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy",  busy,  0);
        chk("t5_rst_start", start, 0);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_tick",  tick,  0);
        chk("t5_rst_flags", {missed, terr}, 0);
        rst_n = 1'b1;
        at(20); chk("t5_no_early", start, 0);
        at(21); chk("t5_restart", start, 1); chk("t5_restart_grant", grant, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sensor_poll_scheduler.md
Name: sensor_poll_scheduler

Overview:
Derives a 1 µs tick and a 1 ms tick from the 26 MHz board clock. Issues periodic poll requests for three sensor slots, each with its own period in ms. Grants a single shared sensor-bus transaction engine to one slot at a time using a start/done handshake and a timeout. Sits between the board clock input and the shared SPI/I2C sequencer in the avionics top level.

Parameters:
CLK_DIV, 26, input clock cycles per 1 µs tick (≥2)
US_PER_MS, 1000, 1 µs ticks per 1 ms tick (≥2)
PERIOD0, 10, slot 0 poll period in ms (≥1)
PERIOD1, 100, slot 1 poll period in ms (≥1)
PERIOD2, 1000, slot 2 poll period in ms (≥1)
TIMEOUT_US, 500, max µs ticks in WAIT before abort (≥1)

Ports:
CLK_26MHZ_IN  input  1  system clock, 26 MHz
RESET  input  1  synchronous reset, active-low
ENABLE  input  1  scheduling enable
DONE  input  1  shared engine finished current transaction (single-cycle pulse)
CLEAR_ERR  input  1  one-cycle pulse, clears sticky flags
TICK_1US  output  1  one-cycle pulse every CLK_DIV clocks
GRANT  output  2  slot index of the current or last transaction (0..2)
START  output  1  one-cycle pulse launching the engine for GRANT
BUSY  output  1  high while in WAIT
MISSED  output  3  sticky per-slot overrun flags
TIMEOUT_ERR  output  3  sticky per-slot timeout flags

Behaviour:
- Reset (RESET=0 at a clock edge): all outputs 0; prescaler, µs counter and timeout counter 0; slot counters load PERIODi-1; pending=0; FSM in IDLE.
- Prescaler: counts 0..CLK_DIV-1 and wraps. TICK_1US=1 in the cycle where prescaler==CLK_DIV-1. First pulse occurs CLK_DIV cycles after reset release. Runs regardless of ENABLE.
- µs counter: counts 0..US_PER_MS-1 and advances on TICK_1US. ms_tick (internal) = TICK_1US and us==US_PER_MS-1.
- Slot counters, ENABLE=1: on ms_tick, if cnt_i==0 then reload PERIODi-1 and set pending[i]; otherwise decrement.
- Slot counters, ENABLE=0: held at PERIODi-1; pending cleared.
- Overrun: set event while pending[i] already 1 → MISSED[i]<=1; pending stays 1 (requests do not queue).
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if ENABLE and any pending, GRANT<=lowest pending index (slot 0 highest priority), go to ISSUE.
  - ISSUE: START=1 for exactly one cycle; clear pending[GRANT]; clear timeout counter; go to WAIT. Latency from pending set to START is 2 cycles when idle.
  - WAIT: BUSY=1. DONE=1 → IDLE. Otherwise the timeout counter increments on TICK_1US. When it reaches TIMEOUT_US: TIMEOUT_ERR[GRANT]<=1, go to IDLE.
- DONE and timeout in the same cycle: DONE wins, no error.
- DONE outside WAIT is ignored.
- Set and clear of pending[i] in the same cycle (ISSUE): set wins; MISSED not flagged.
- ENABLE falling during ISSUE or WAIT: the in-flight transaction completes or times out normally; no new grant afterwards.
- CLEAR_ERR: clears MISSED and TIMEOUT_ERR. A set event in the same cycle wins.
- GRANT holds its value after return to IDLE.

Test Plan (overrides CLK_DIV=4, US_PER_MS=5, PERIOD0=1, PERIOD1=2, PERIOD2=4, TIMEOUT_US=3; ms_tick every 20 clocks):
- Reset release, ENABLE=0 → TICK_1US pulses at cycles 4, 8, 12…; START never asserts; all flags 0.
- ENABLE=1 from reset, DONE returned 2 cycles after each START → slot 0 START every 20 cycles; slot 1 every 40; slot 2 every 80. When slots collide, order is 0 then 1 then 2; MISSED=000.
- DONE withheld → BUSY high ~12 cycles (3 µs ticks) → TIMEOUT_ERR[0]=1, return to IDLE; CLEAR_ERR pulse → TIMEOUT_ERR=000.
- DONE withheld and TIMEOUT_US raised to 10 → second slot-0 period expires while pending → MISSED[0]=1.
- DONE coincident with the timeout tick → no TIMEOUT_ERR; DONE pulse while IDLE → no state change.
- RESET asserted mid-WAIT → next cycle BUSY=0, START=0, GRANT=0, flags 0; schedule restarts from first ms_tick.
